core_fpu_wb: RTL

CORE_FPU_WB -- requirements
Module: core_fpu_wb

---
 rtl/core_fpu_pkg.sv | 15 +
 rtl/core_fpu_wb_hzd.sv | 39 +++
 rtl/core_fpu_wb.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/core_fpu_pkg.sv
// Shared types and constants for the FPU writeback tracker.
package core_fpu_pkg;

  localparam int REG_W           = 5;
  localparam int DATA_W          = 32;
  localparam int ARM_TIMEOUT_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_BUSY = 2'd2,
    ST_WB   = 2'd3
  } state_e;

endpackage

// File: rtl/core_fpu_wb_hzd.sv
// Decode-stage hazard comparator against the pending FPU destination.
// With CORE_FPU_WB_FWD_EN defined, the WB cycle is covered by forwarding instead.
module core_fpu_wb_hzd
  import core_fpu_pkg::*;
(
  input  state_e           state,
  input  logic [REG_W-1:0] rd,
  input  logic             to_int,
  input  logic [REG_W-1:0] src_a,
  input  logic [REG_W-1:0] src_b,
  input  logic [REG_W-1:0] src_c,
  input  logic [2:0]       src_is_fp,
  output logic             hazard
);

  logic [2:0][REG_W-1:0] srcs;
  logic [2:0]            match;
  logic                  active;

  assign srcs = {src_c, src_b, src_a};

  // Integer x0 is hardwired, so it can never be a real dependency.
  always_comb begin
    match = '0;
    for (int k = 0; k < 3; k++) begin
      match[k] = (srcs[k] == rd) && (src_is_fp[k] == !to_int) &&
                 (src_is_fp[k] || (srcs[k] != '0));
    end
  end

`ifdef CORE_FPU_WB_FWD_EN
  assign active = (state == ST_ARM) || (state == ST_BUSY);
`else
  assign active = (state != ST_IDLE);
`endif

  assign hazard = active && (|match);

endmodule

// File: rtl/core_fpu_wb.sv
// Tracks one in-flight FPU operation and writes its result back to the FP or integer file.
// Optional forwarding of the WB-cycle result is enabled by CORE_FPU_WB_FWD_EN.
//
// state   | meaning
// IDLE    | nothing pending, accepts i_issue
// ARM     | issued, waiting for fpu_stole to rise (bounded by ARM_TIMEOUT)
// BUSY    | FPU working, waiting for fpu_stole to fall
// WB      | registered write port active this cycle
module core_fpu_wb
  import core_fpu_pkg::*;
#(
  parameter int ARM_TIMEOUT = ARM_TIMEOUT_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              i_issue,
  input  logic [REG_W-1:0]  i_rd,
  input  logic              i_to_int,
  input  logic              i_flush,
  input  logic              fpu_stole,
  input  logic [DATA_W-1:0] fpu_result,
  input  logic [REG_W-1:0]  i_src_a,
  input  logic [REG_W-1:0]  i_src_b,
  input  logic [REG_W-1:0]  i_src_c,
  input  logic [2:0]        i_src_is_fp,
  output logic              o_hazard,
  output logic              o_fwe,
  output logic [REG_W-1:0]  o_fwaddr,
  output logic [DATA_W-1:0] o_fwdata,
  output logic              o_iwe,
  output logic [REG_W-1:0]  o_iwaddr,
  output logic [DATA_W-1:0] o_iwdata,
  output logic              o_busy,
  output logic              o_err
`ifdef CORE_FPU_WB_FWD_EN
  ,
  output logic              o_fwd_valid,
  output logic [DATA_W-1:0] o_fwd_data
`endif
);

  localparam int TMO_W = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ARM_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [REG_W-1:0]    rd_q, rd_d;
  logic                int_q, int_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                stole_q, stole_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                fwe_q, fwe_d, iwe_q, iwe_d, err_q, err_d;
  logic [REG_W-1:0]    fwaddr_q, fwaddr_d, iwaddr_q, iwaddr_d;
  logic [DATA_W-1:0]   fwdata_q, fwdata_d, iwdata_q, iwdata_d;

  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    int_d    = int_q;
    res_d    = res_q;
    stole_d  = fpu_stole;
    tmo_d    = tmo_q;
    fwe_d    = 1'b0;
    iwe_d    = 1'b0;
    err_d    = 1'b0;
    fwaddr_d = fwaddr_q;
    fwdata_d = fwdata_q;
    iwaddr_d = iwaddr_q;
    iwdata_d = iwdata_q;

    case (state_q)
      ST_IDLE: begin
        if (i_issue) begin
          state_d = ST_ARM;
          rd_d    = i_rd;
          int_d   = i_to_int;
          tmo_d   = '0;
        end
      end
      ST_ARM: begin
        if (fpu_stole) begin
          state_d = ST_BUSY;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_BUSY: begin
        // Write flops load on the falling edge so the port is live during WB itself.
        if (stole_q && !fpu_stole) begin
          state_d = ST_WB;
          res_d   = fpu_result;
          if (int_q) begin
            if (rd_q != '0) begin
              iwe_d    = 1'b1;
              iwaddr_d = rd_q;
              iwdata_d = fpu_result;
            end
          end else begin
            fwe_d    = 1'b1;
            fwaddr_d = rd_q;
            fwdata_d = fpu_result;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (i_issue && (state_q != ST_IDLE)) err_d = 1'b1;

    if (i_flush) begin
      state_d  = ST_IDLE;
      rd_d     = rd_q;
      int_d    = int_q;
      res_d    = res_q;
      fwe_d    = 1'b0;
      iwe_d    = 1'b0;
      err_d    = 1'b0;
      fwaddr_d = fwaddr_q;
      fwdata_d = fwdata_q;
      iwaddr_d = iwaddr_q;
      iwdata_d = iwdata_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      rd_q     <= '0;
      int_q    <= 1'b0;
      res_q    <= '0;
      stole_q  <= 1'b0;
      tmo_q    <= '0;
      fwe_q    <= 1'b0;
      iwe_q    <= 1'b0;
      err_q    <= 1'b0;
      fwaddr_q <= '0;
      fwdata_q <= '0;
      iwaddr_q <= '0;
      iwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      int_q    <= int_d;
      res_q    <= res_d;
      stole_q  <= stole_d;
      tmo_q    <= tmo_d;
      fwe_q    <= fwe_d;
      iwe_q    <= iwe_d;
      err_q    <= err_d;
      fwaddr_q <= fwaddr_d;
      fwdata_q <= fwdata_d;
      iwaddr_q <= iwaddr_d;
      iwdata_q <= iwdata_d;
    end
  end

  core_fpu_wb_hzd u_hzd (
    .state     (state_q),
    .rd        (rd_q),
    .to_int    (int_q),
    .src_a     (i_src_a),
    .src_b     (i_src_b),
    .src_c     (i_src_c),
    .src_is_fp (i_src_is_fp),
    .hazard    (o_hazard)
  );

  assign o_fwe    = fwe_q;
  assign o_fwaddr = fwaddr_q;
  assign o_fwdata = fwdata_q;
  assign o_iwe    = iwe_q;
  assign o_iwaddr = iwaddr_q;
  assign o_iwdata = iwdata_q;
  assign o_err    = err_q;
  assign o_busy   = (state_q != ST_IDLE);

`ifdef CORE_FPU_WB_FWD_EN
  assign o_fwd_valid = (state_q == ST_WB);
  assign o_fwd_data  = res_q;
`endif

endmodule
